// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receive and transmit paths.
package ps2_pkg;

  localparam int PS2_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAMING = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/ps2_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// The head entry is visible on o_rdData whenever the FIFO is not empty.
module ps2_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_wrEn,
  input  logic [WIDTH-1:0]         i_wrData,
  input  logic                     i_rdEn,
  output logic [WIDTH-1:0]         o_rdData,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  // A pop frees a slot in the same cycle, so a write to a full FIFO succeeds alongside it.
  assign w_pop  = i_rdEn & ~o_empty;
  assign w_push = i_wrEn & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= i_wrData;
        r_wrPtr        <= r_wrPtr + 1'b1;
      end
      if (w_pop) r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdData = r_mem[r_rdPtr];
  assign o_count  = r_count;
  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == FULL_COUNT);

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: oversampled frame decoder with parity/framing/timeout
// checks, a scan-code FIFO for the host and a byte history for the display.
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int BUF_BYTES      = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          kb_clk,
  input  logic                          kb_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [8*BUF_BYTES-1:0]        buffer_out,
  output logic                          frame_done,
  output logic                          error,
  output logic [1:0]                    err_code,
  output logic                          overflow
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      LAST_BIT = 3'(PS2_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0] r_clkSync;
  logic [SYNC_STAGES-1:0] r_dataSync;
  logic                   r_kbClkPrev;
  ps2_state_e             r_state;
  logic [2:0]             r_bitCnt;
  logic [7:0]             r_shift;
  logic                   r_xor;
  logic                   r_parityBad;
  logic [TO_W-1:0]        r_toCnt;

  logic                   w_kbClk;
  logic                   w_kbData;
  logic                   w_fe;
  logic                   w_goodFrame;
  logic                   w_fifoEmpty;
  logic                   w_fifoFull;
  logic [8*BUF_BYTES-1:0] w_bufNext;

  // Synchronisers reset to 1 so an idle bus does not look like a falling edge.
  if (SYNC_STAGES >= 2) begin : g_sync
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_clkSync  <= '1;
        r_dataSync <= '1;
      end else begin
        r_clkSync  <= {r_clkSync[SYNC_STAGES-2:0], kb_clk};
        r_dataSync <= {r_dataSync[SYNC_STAGES-2:0], kb_data};
      end
    end
  end

  assign w_kbClk     = r_clkSync[SYNC_STAGES-1];
  assign w_kbData    = r_dataSync[SYNC_STAGES-1];
  assign w_fe        = r_kbClkPrev & ~w_kbClk;
  assign w_goodFrame = w_fe & (r_state == STOP) & w_kbData & ~r_parityBad;

  if (BUF_BYTES == 1) begin : g_buf1
    assign w_bufNext = r_shift;
  end else begin : g_bufN
    assign w_bufNext = {buffer_out[8*BUF_BYTES-9:0], r_shift};
  end

  // Frame decoder; the watchdog takes priority unless an edge arrives in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_kbClkPrev <= 1'b1;
      r_state     <= IDLE;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_xor       <= 1'b0;
      r_parityBad <= 1'b0;
      r_toCnt     <= '0;
      buffer_out  <= '0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      err_code    <= ERR_NONE;
      overflow    <= 1'b0;
    end else begin
      r_kbClkPrev <= w_kbClk;
      frame_done  <= w_goodFrame;
      if (w_goodFrame && w_fifoFull && !rd_en) overflow <= 1'b1;

      if (r_state == IDLE || w_fe) r_toCnt <= '0;
      else                         r_toCnt <= r_toCnt + 1'b1;

      if (r_state != IDLE && !w_fe && r_toCnt == TO_LAST) begin
        r_state  <= IDLE;
        error    <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end else if (w_fe) begin
        case (r_state)
          IDLE: begin
            if (!w_kbData) begin
              r_state  <= DATA;
              r_bitCnt <= '0;
              r_xor    <= 1'b0;
              error    <= 1'b0;
              err_code <= ERR_NONE;
            end
          end
          DATA: begin
            r_shift  <= {w_kbData, r_shift[7:1]};
            r_xor    <= r_xor ^ w_kbData;
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == LAST_BIT) r_state <= PARITY;
          end
          PARITY: begin
            r_parityBad <= ~(r_xor ^ w_kbData);
            r_state     <= STOP;
          end
          STOP: begin
            r_state <= IDLE;
            if (!w_kbData) begin
              error    <= 1'b1;
              err_code <= ERR_FRAMING;
            end else if (r_parityBad) begin
              error    <= 1'b1;
              err_code <= ERR_PARITY;
            end else begin
              buffer_out <= w_bufNext;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  ps2_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_DATA_BITS)
  ) u_fifo (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_wrEn   (w_goodFrame),
    .i_wrData (r_shift),
    .i_rdEn   (rd_en),
    .o_rdData (rd_data),
    .o_count  (fifo_count),
    .o_empty  (w_fifoEmpty),
    .o_full   (w_fifoFull)
  );

  assign rd_valid = ~w_fifoEmpty;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frame-level reference model checked every
// cycle, plus literal expectations for each scenario.
module tb_ps2_rx_fifo;

  localparam int CLK_PERIOD     = 10;
  localparam int FIFO_DEPTH     = 4;
  localparam int BUF_BYTES      = 2;
  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kb_clk;
  logic        kb_data;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [2:0]  fifo_count;
  logic [15:0] buffer_out;
  logic        frame_done;
  logic        error;
  logic [1:0]  err_code;
  logic        overflow;

  // Reference model state: what a host would observe, at frame granularity.
  logic [7:0]  expQ[$];
  logic [15:0] expBuf;
  logic        expError;
  logic [1:0]  expErrCode;
  logic        expOverflow;
  logic        expFrameDone;
  int          nBits;
  logic [10:0] rxBits;
  time         lastFeTime;

  bit checking;
  int nChecks;
  int nPass;
  int doneCount;

  always #(CLK_PERIOD/2) clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .BUF_BYTES      (BUF_BYTES),
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kb_clk     (kb_clk),
    .kb_data    (kb_data),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .fifo_count (fifo_count),
    .buffer_out (buffer_out),
    .frame_done (frame_done),
    .error      (error),
    .err_code   (err_code),
    .overflow   (overflow)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, expected, $time);
  endtask

  task automatic modelReset();
    expQ.delete();
    expBuf       = '0;
    expError     = 1'b0;
    expErrCode   = 2'd0;
    expOverflow  = 1'b0;
    expFrameDone = 1'b0;
    nBits        = 0;
    rxBits       = '0;
    lastFeTime   = 0;
  endtask

  task automatic modelPop();
    if (expQ.size() > 0) expQ.delete(0);
  endtask

  // Collects one frame bit per kb_clk fall and judges the frame once all 11 bits are in.
  task automatic modelBit(input logic b);
    logic [7:0] value;
    lastFeTime = $time;
    if (nBits == 0) begin
      if (b == 1'b0) begin
        nBits      = 1;
        expError   = 1'b0;
        expErrCode = 2'd0;
      end
    end else begin
      rxBits[nBits] = b;
      nBits++;
      if (nBits == 11) begin
        nBits = 0;
        value = rxBits[8:1];
        if (b == 1'b0) begin
          expError   = 1'b1;
          expErrCode = 2'd2;
        end else if (($countones(rxBits[9:1]) % 2) == 0) begin
          expError   = 1'b1;
          expErrCode = 2'd1;
        end else begin
          expFrameDone = 1'b1;
          expBuf       = {expBuf[7:0], value};
          if (expQ.size() < FIFO_DEPTH) expQ.push_back(value);
          else                          expOverflow = 1'b1;
        end
      end
    end
  endtask

  task automatic modelTimeout();
    if (nBits != 0) begin
      nBits      = 0;
      expError   = 1'b1;
      expErrCode = 2'd3;
    end
  endtask

  // One PS/2 bit: data set up, kb_clk low, model updated on the clk edge the DUT reacts on.
  task automatic applyStimulus(input logic b, input bit popHere);
    kb_data = b;
    repeat (HALF) @(negedge clk);
    kb_clk = 1'b0;
    repeat (SYNC_STAGES) @(posedge clk);
    @(negedge clk);
    if (popHere) rd_en = 1'b1;
    @(posedge clk);
    if (popHere) modelPop();
    modelBit(b);
    @(negedge clk);
    rd_en = 1'b0;
    @(posedge clk);
    expFrameDone = 1'b0;
    @(negedge clk);
    repeat (HALF) @(negedge clk);
    kb_clk = 1'b1;
  endtask

  function automatic logic [10:0] makeFrame(input logic [7:0] value, input bit badPar, input logic stopBit);
    logic par;
    par = ~(^value);
    if (badPar) par = ~par;
    return {stopBit, par, value, 1'b0};
  endfunction

  task automatic sendBits(input logic [10:0] frame, input int first, input int last, input bit popAtStop);
    for (int i = first; i <= last; i++) applyStimulus(frame[i], popAtStop && (i == 10));
  endtask

  task automatic sendFrame(input logic [7:0] value, input bit badPar, input logic stopBit);
    sendBits(makeFrame(value, badPar, stopBit), 0, 10, 1'b0);
  endtask

  task automatic readByte(input logic [7:0] expected);
    checkOutput("read_valid", rd_valid, 1'b1);
    checkOutput("read_data", rd_data, expected);
    rd_en = 1'b1;
    @(posedge clk);
    modelPop();
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  // Every-cycle comparison of the DUT against the reference model.
  always @(negedge clk) begin
    if (checking) begin
      #1;
      checkOutput("rd_valid", rd_valid, expQ.size() != 0);
      if (expQ.size() != 0) checkOutput("rd_data", rd_data, expQ[0]);
      checkOutput("fifo_count", fifo_count, expQ.size());
      checkOutput("buffer_out", buffer_out, expBuf);
      checkOutput("frame_done", frame_done, expFrameDone);
      checkOutput("error", error, expError);
      checkOutput("err_code", err_code, expErrCode);
      checkOutput("overflow", overflow, expOverflow);
    end
  end

  always @(negedge clk) if (frame_done === 1'b1) doneCount++;

  initial begin
    int doneBase;
    logic [10:0] f;
    nChecks   = 0;
    nPass     = 0;
    doneCount = 0;
    checking  = 1'b0;
    rst_n     = 1'b0;
    kb_clk    = 1'b1;
    kb_data   = 1'b1;
    rd_en     = 1'b0;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("reset_rd_valid", rd_valid, 1'b0);
    checkOutput("reset_rd_data", rd_data, 8'h00);
    checkOutput("reset_count", fifo_count, 3'd0);
    checkOutput("reset_buffer", buffer_out, 16'h0000);
    checkOutput("reset_error", {error, err_code, overflow, frame_done}, 5'b0);
    rst_n    = 1'b1;
    checking = 1'b1;

    $display("[TB] two good frames");
    doneBase = doneCount;
    sendFrame(8'h1C, 1'b0, 1'b1);
    sendFrame(8'hF0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("t1_done_pulses", doneCount - doneBase, 2);
    checkOutput("t1_buffer", buffer_out, 16'h1CF0);
    checkOutput("t1_count", fifo_count, 3'd2);
    readByte(8'h1C);
    readByte(8'hF0);
    checkOutput("t1_drained", rd_valid, 1'b0);

    $display("[TB] parity error then recovery");
    doneBase = doneCount;
    sendFrame(8'h1C, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("t2_err_code", {error, err_code}, 3'b101);
    checkOutput("t2_no_done", doneCount - doneBase, 0);
    checkOutput("t2_buffer", buffer_out, 16'h1CF0);
    checkOutput("t2_count", fifo_count, 3'd0);
    f = makeFrame(8'h5A, 1'b0, 1'b1);
    sendBits(f, 0, 0, 1'b0);
    checkOutput("t2_err_cleared", {error, err_code}, 3'b000);
    sendBits(f, 1, 10, 1'b0);
    @(negedge clk);
    checkOutput("t2_buffer_5a", buffer_out, 16'hF05A);
    readByte(8'h5A);

    $display("[TB] framing errors");
    sendFrame(8'h1C, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("t3_framing", {error, err_code}, 3'b110);
    sendFrame(8'h1C, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("t3_framing_over_parity", {error, err_code}, 3'b110);
    checkOutput("t3_count", fifo_count, 3'd0);

    $display("[TB] watchdog timeout");
    sendBits(makeFrame(8'h1C, 1'b0, 1'b1), 0, 4, 1'b0);
    while ($time < lastFeTime + TIMEOUT_CYCLES * CLK_PERIOD) @(posedge clk);
    modelTimeout();
    repeat (10) @(negedge clk);
    checkOutput("t4_timeout", {error, err_code}, 3'b111);
    sendFrame(8'h29, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t4_recovered", {error, buffer_out[7:0]}, {1'b0, 8'h29});
    readByte(8'h29);

    $display("[TB] overflow and full-FIFO push with pop");
    for (int v = 1; v <= 5; v++) sendFrame(8'(v), 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t5_count_full", fifo_count, 3'd4);
    checkOutput("t5_overflow", overflow, 1'b1);
    checkOutput("t5_buffer_low", buffer_out[7:0], 8'h05);
    for (int v = 1; v <= 4; v++) readByte(8'(v));
    rd_en = 1'b1;
    @(posedge clk);
    modelPop();
    @(negedge clk);
    rd_en = 1'b0;
    checkOutput("t5_empty_read", {rd_valid, fifo_count}, 4'b0000);
    for (int v = 8'h11; v <= 8'h14; v++) sendFrame(8'(v), 1'b0, 1'b1);
    doneBase = doneCount;
    sendBits(makeFrame(8'h15, 1'b0, 1'b1), 0, 10, 1'b1);
    @(negedge clk);
    checkOutput("t5_push_pop_count", fifo_count, 3'd4);
    checkOutput("t5_push_pop_done", doneCount - doneBase, 1);
    for (int v = 8'h12; v <= 8'h15; v++) readByte(8'(v));

    $display("[TB] reset mid-frame");
    sendBits(makeFrame(8'h1C, 1'b0, 1'b1), 0, 5, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    #2;
    checkOutput("t6_reset_outputs", {rd_valid, fifo_count, error, err_code, overflow, frame_done}, 9'b0);
    checkOutput("t6_reset_buffer", buffer_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    sendFrame(8'h32, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("t6_only_32", {fifo_count, rd_data, error}, {3'd1, 8'h32, 1'b0});
    checkOutput("t6_buffer", buffer_out, 16'h0032);
    readByte(8'h32);

    repeat (5) @(negedge clk);
    checking = 1'b0;
    #2;
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
